// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with grant locking: a grantee keeps the port for
// whole transactions and may take up to WEIGHT consecutive tenures before rotation.
module wrr_lock_arbiter #(
  parameter int N = 4,
  parameter int WGT_W = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WGT_W-1:0]   weight,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [WGT_W-1:0]   credit_q, credit_d;
  logic [N-1:0]       grant_q, grant_d;
  logic               grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;

  logic [WGT_W-1:0]   w_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_wsplit
    assign w_arr[gi] = weight[gi*WGT_W +: WGT_W];
  end

  // A zero weight still buys one tenure.
  function automatic logic [WGT_W-1:0] load_val(input logic [WGT_W-1:0] w);
    return (w == '0) ? WGT_W'(1) : w;
  endfunction

  // Returns {found, index} of the first set bit of r searching base, base+1, .. with wrap.
  function automatic logic [IDX_W:0] pick_first(input logic [N-1:0] r,
                                                input logic [IDX_W-1:0] base);
    logic [IDX_W:0]   res;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] j;
    res = '0;
    for (int k = N-1; k >= 0; k--) begin
      sum = {1'b0, base} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      j = sum[IDX_W-1:0];
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  logic [IDX_W:0]   idle_pick;
  logic [IDX_W:0]   busy_pick;
  logic [IDX_W-1:0] ptr_wrap;
  logic [WGT_W-1:0] credit_dec;
  logic             g_req;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    credit_d      = credit_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;

    g_req      = req[grant_idx_q];
    ptr_wrap   = (grant_idx_q == IDX_W'(N-1)) ? '0 : grant_idx_q + 1'b1;
    idle_pick  = pick_first(req, ptr_q);
    // The current grantee is excluded so that rotation is real, not a self re-win.
    busy_pick  = pick_first(req & ~grant_q, ptr_wrap);
    credit_dec = credit_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (idle_pick[IDX_W]) begin
          grant_d                       = '0;
          grant_d[idle_pick[IDX_W-1:0]] = 1'b1;
          grant_idx_d                   = idle_pick[IDX_W-1:0];
          grant_valid_d                 = 1'b1;
          credit_d                      = load_val(w_arr[idle_pick[IDX_W-1:0]]);
          state_d                       = BUSY;
        end
      end
      BUSY: begin
        if (done || !g_req) begin
          if (done && g_req && credit_dec != '0) begin
            credit_d = credit_dec;
          end else begin
            ptr_d = ptr_wrap;
            if (busy_pick[IDX_W]) begin
              grant_d                       = '0;
              grant_d[busy_pick[IDX_W-1:0]] = 1'b1;
              grant_idx_d                   = busy_pick[IDX_W-1:0];
              credit_d                      = load_val(w_arr[busy_pick[IDX_W-1:0]]);
            end else if (done && g_req) begin
              credit_d = load_val(w_arr[grant_idx_q]);
            end else begin
              grant_d       = '0;
              grant_valid_d = 1'b0;
              grant_idx_d   = '0;
              credit_d      = '0;
              state_d       = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      credit_q      <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      credit_q      <= credit_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Bench for wrr_lock_arbiter: vector table, directed corner sequences, and
// randomized traffic checked against an owner/tenures-left reference model.
module tb_wrr_lock_arbiter;

  localparam int N     = 4;
  localparam int WGT_W = 3;
  localparam int IDX_W = 2;
  localparam int WW    = N*WGT_W;

  localparam logic [WW-1:0] W_ALL1 = {3'd1, 3'd1, 3'd1, 3'd1};
  localparam logic [WW-1:0] W_T3   = {3'd1, 3'd3, 3'd1, 3'd1};
  localparam logic [WW-1:0] W_T5   = {3'd1, 3'd4, 3'd1, 3'd1};
  localparam logic [WW-1:0] W_T6   = {3'd1, 3'd1, 3'd0, 3'd1};

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [WW-1:0]    weight;
  logic             done;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  wrr_lock_arbiter #(.N(N), .WGT_W(WGT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .weight     (weight),
    .done       (done),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0]     req;
    logic             done;
    logic [WW-1:0]    weight;
    logic [N-1:0]     exp_grant;
    logic             exp_valid;
    logic [IDX_W-1:0] exp_idx;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [N-1:0] r, input logic d, input logic [WW-1:0] w,
                         input logic [N-1:0] g, input logic v, input logic [IDX_W-1:0] i);
    vec_t t;
    t.req = r; t.done = d; t.weight = w;
    t.exp_grant = g; t.exp_valid = v; t.exp_idx = i;
    vecs.push_back(t);
  endtask

  task automatic check_out(input string name, input logic [N-1:0] eg, input logic ev,
                           input logic [IDX_W-1:0] ei);
    n_checks++;
    if (grant !== eg || grant_valid !== ev || (ev && grant_idx !== ei)) begin
      n_fail++;
      $display("FAIL %s: got grant=%b valid=%b idx=%0d, expected grant=%b valid=%b idx=%0d",
               name, grant, grant_valid, grant_idx, eg, ev, ei);
    end else begin
      $display("ok   %s: grant=%b valid=%b idx=%0d", name, grant, grant_valid, grant_idx);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the port and how many tenures it has left.
  int m_owner;
  int m_ptr;
  int m_left;

  function automatic int wv(input logic [WW-1:0] w, input int i);
    logic [WW-1:0] t;
    int v;
    t = w >> (i*WGT_W);
    v = int'(t[WGT_W-1:0]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int find(input logic [N-1:0] r, input int start, input int excl);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (start + k) % N;
      if (j != excl && r[IDX_W'(j)]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_left = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic d, input logic [WW-1:0] w);
    int old;
    int nxt;
    if (m_owner < 0) begin
      nxt = find(r, m_ptr, -1);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_left  = wv(w, nxt);
      end
    end else begin
      old = m_owner;
      if (d) m_left = m_left - 1;
      if (!r[IDX_W'(old)] || (d && m_left == 0)) begin
        m_ptr = (old + 1) % N;
        nxt = find(r, m_ptr, old);
        if (nxt >= 0) begin
          m_owner = nxt;
          m_left  = wv(w, nxt);
        end else if (d && r[IDX_W'(old)]) begin
          m_left = wv(w, old);
        end else begin
          m_owner = -1;
          m_left  = 0;
        end
      end
    end
  endtask

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] eg;

    rst = 1'b1; req = '0; done = 1'b0; weight = W_ALL1;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    // Weighted rotation {w3..w0}={1,3,1,1}, done every cycle.
    add_vec(4'b1111, 1'b0, W_T3, 4'b0001, 1'b1, 2'd0);
    add_vec(4'b1111, 1'b1, W_T3, 4'b0010, 1'b1, 2'd1);
    add_vec(4'b1111, 1'b1, W_T3, 4'b0100, 1'b1, 2'd2);
    add_vec(4'b1111, 1'b1, W_T3, 4'b0100, 1'b1, 2'd2);
    add_vec(4'b1111, 1'b1, W_T3, 4'b0100, 1'b1, 2'd2);
    add_vec(4'b1111, 1'b1, W_T3, 4'b1000, 1'b1, 2'd3);
    add_vec(4'b1111, 1'b1, W_T3, 4'b0001, 1'b1, 2'd0);
    add_vec(4'b0000, 1'b0, W_T3, 4'b0000, 1'b0, 2'd0);
    // Two requesters, unit weights: alternate with no bubble.
    add_vec(4'b0110, 1'b0, W_ALL1, 4'b0010, 1'b1, 2'd1);
    add_vec(4'b0110, 1'b1, W_ALL1, 4'b0100, 1'b1, 2'd2);
    add_vec(4'b0110, 1'b1, W_ALL1, 4'b0010, 1'b1, 2'd1);
    add_vec(4'b0110, 1'b1, W_ALL1, 4'b0100, 1'b1, 2'd2);
    add_vec(4'b0000, 1'b0, W_ALL1, 4'b0000, 1'b0, 2'd0);
    // Weight 0 acts as 1; a sole requester is re-granted continuously.
    add_vec(4'b0010, 1'b0, W_T6, 4'b0010, 1'b1, 2'd1);
    add_vec(4'b0010, 1'b1, W_T6, 4'b0010, 1'b1, 2'd1);
    add_vec(4'b0010, 1'b1, W_T6, 4'b0010, 1'b1, 2'd1);
    add_vec(4'b0000, 1'b1, W_T6, 4'b0000, 1'b0, 2'd0);
    // done while idle is ignored.
    add_vec(4'b0000, 1'b1, W_T6, 4'b0000, 1'b0, 2'd0);

    foreach (vecs[i]) begin
      req = vecs[i].req; done = vecs[i].done; weight = vecs[i].weight;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_valid, vecs[i].exp_idx);
    end

    // Asynchronous reset mid-tenure, then a fresh grant one edge after release.
    weight = W_ALL1; req = 4'b0100; done = 1'b0;
    step();
    check_out("pre_rst_grant", 4'b0100, 1'b1, 2'd2);
    #2 rst = 1'b1;
    #1 check_out("async_rst", 4'b0000, 1'b0, 2'd0);
    req = 4'b0001;
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    check_out("post_rst_grant", 4'b0001, 1'b1, 2'd0);

    // Lock: grant held while done stays low, then hands over on done.
    req = 4'b0011; done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check_out($sformatf("lock_hold%0d", c), 4'b0001, 1'b1, 2'd0);
    end
    done = 1'b1;
    step();
    check_out("lock_release", 4'b0010, 1'b1, 2'd1);

    // Abandon with credit left moves ptr past the grantee.
    weight = W_T5; done = 1'b0; req = 4'b0100;
    step();
    check_out("abandon_setup", 4'b0100, 1'b1, 2'd2);
    req = 4'b1100; done = 1'b1;
    step();
    check_out("abandon_credit", 4'b0100, 1'b1, 2'd2);
    req = 4'b1001; done = 1'b0;
    step();
    check_out("abandon_ptr", 4'b1000, 1'b1, 2'd3);

    // Randomized traffic against the reference model.
    rst = 1'b1; req = '0; done = 1'b0;
    step();
    #4 rst = 1'b0;
    model_reset();
    rq = N'($urandom);
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom);
      if (c % 64 == 0) weight = WW'($urandom);
      req  = rq;
      done = ($urandom_range(0, 2) == 0);
      model_step(req, done, weight);
      step();
      eg = '0;
      if (m_owner >= 0) eg[IDX_W'(m_owner)] = 1'b1;
      check_out($sformatf("rand%0d", c), eg, (m_owner >= 0),
                (m_owner >= 0) ? IDX_W'(m_owner) : 2'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
